// File: rtl/cache_pkg.sv
// Shared definitions for the L1/L2 cache slice: arbiter FSM encodings,
// grant codes and requester identifiers used by the L1 controllers.
package cache_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_GRANT_I = 2'b01,
        S_GRANT_D = 2'b10,
        S_RELEASE = 2'b11
    } arb_state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_I    = 2'b01;
    localparam logic [1:0] GRANT_D    = 2'b10;

    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;

    localparam int WDOG_W = 8;

endpackage

// File: rtl/l1_l2_arbiter.sv
// Two-way arbiter sharing one L2 port between the I-side and D-side L1s,
// with alternating tie-break, registered L2 request and a grant watchdog.
module l1_l2_arbiter
    import cache_pkg::*;
#(
    parameter int TNUM2  = 18,
    parameter int INUM2  = 8,
    parameter int TO_CYC = 255
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             read_I_L2,
    input  logic [TNUM2-1:0] tag_I_L2,
    input  logic [INUM2-1:0] index_I_L2,
    input  logic             read_D_L2,
    input  logic             write_D_L2,
    input  logic [TNUM2-1:0] tag_D_L2,
    input  logic [INUM2-1:0] index_D_L2,
    output logic             ready_L2_I,
    output logic             ready_L2_D,
    output logic             read_L1_L2,
    output logic             write_L1_L2,
    output logic [TNUM2-1:0] tag_L1_L2,
    output logic [INUM2-1:0] index_L1_L2,
    input  logic             ready_L2_L1,
    output logic [1:0]       grant_o,
    output logic             timeout_o
);

    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TO_CYC - 1);

    arb_state_t        r_state;
    arb_state_t        w_nextState;
    logic              r_lastGrant;
    logic [TNUM2-1:0]  r_tag;
    logic [INUM2-1:0]  r_index;
    logic              r_write;
    logic [WDOG_W-1:0] r_wdog;
    logic              r_timeout;

    logic w_reqI;
    logic w_reqD;
    logic w_pickD;
    logic w_start;
    logic w_granted;
    logic w_wdogHit;

    assign w_reqI    = read_I_L2;
    assign w_reqD    = read_D_L2 | write_D_L2;
    // On a tie the side that did not win last time gets the port.
    assign w_pickD   = w_reqD & (~w_reqI | (r_lastGrant == LAST_I));
    assign w_start   = (r_state == S_IDLE) & (w_reqI | w_reqD);
    assign w_granted = (r_state == S_GRANT_I) | (r_state == S_GRANT_D);
    assign w_wdogHit = (r_wdog == WDOG_LAST);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_nextState = w_pickD ? S_GRANT_D : S_GRANT_I;
                end
            end
            S_GRANT_I, S_GRANT_D: begin
                if (ready_L2_L1 || w_wdogHit) begin
                    w_nextState = S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Winner's address/op are captured once so L2 never sees requester churn.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_lastGrant <= LAST_D;
            r_tag       <= '0;
            r_index     <= '0;
            r_write     <= 1'b0;
            r_wdog      <= '0;
            r_timeout   <= 1'b0;
        end else if (w_start) begin
            r_lastGrant <= w_pickD ? LAST_D : LAST_I;
            r_tag       <= w_pickD ? tag_D_L2 : tag_I_L2;
            r_index     <= w_pickD ? index_D_L2 : index_I_L2;
            r_write     <= w_pickD & write_D_L2;
            r_wdog      <= '0;
        end else if (w_granted) begin
            r_wdog <= r_wdog + 1'b1;
            if (!ready_L2_L1 && w_wdogHit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    always_comb begin
        grant_o     = GRANT_NONE;
        read_L1_L2  = 1'b0;
        write_L1_L2 = 1'b0;
        ready_L2_I  = 1'b0;
        ready_L2_D  = 1'b0;
        tag_L1_L2   = r_tag;
        index_L1_L2 = r_index;
        timeout_o   = r_timeout;
        unique case (r_state)
            S_GRANT_I: begin
                grant_o    = GRANT_I;
                read_L1_L2 = 1'b1;
                ready_L2_I = ready_L2_L1;
            end
            S_GRANT_D: begin
                grant_o     = GRANT_D;
                read_L1_L2  = ~r_write;
                write_L1_L2 = r_write;
                ready_L2_D  = ready_L2_L1;
            end
            default: begin
                grant_o = GRANT_NONE;
            end
        endcase
    end

endmodule
